pipe_scheduler: RTL and testbench



---
 rtl/pipe_scheduler.sv | 177 +++++++++++++++++
 tb/tb_pipe_scheduler.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scheduler.sv
// Purpose: scrolls up to three pipe slots, spawns new pipes, and counts the pipes the bird passes.
// Latency: all outputs are registered; each input effect is visible one cycle after it is sampled.
// Backpressure: none; pulse inputs are acted on in the cycle they are seen and never stalled.
module pipe_scheduler #(
    parameter int SPAWN_X   = 640,
    parameter int SPEED     = 4,
    parameter int SPACING   = 240,
    parameter int BIRD_X    = 160,
    parameter int GAP_MIN   = 100,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        initalize,
    input  logic        start,
    input  logic        halt,
    input  logic        frame_tick,
    output logic [10:0] pipe_x0,
    output logic [10:0] pipe_x1,
    output logic [10:0] pipe_x2,
    output logic [9:0]  gap_y0,
    output logic [9:0]  gap_y1,
    output logic [9:0]  gap_y2,
    output logic [2:0]  pipe_active,
    output logic [7:0]  score,
    output logic        pass_pulse,
    output logic        spawn_miss,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } state_t;

    localparam logic [10:0] SPAWN_XV = SPAWN_X[10:0];
    localparam logic [10:0] SPEED_V  = SPEED[10:0];
    localparam logic [10:0] SPACE_V  = SPACING[10:0];
    localparam logic [10:0] BIRD_V   = BIRD_X[10:0];
    localparam logic [9:0]  GAPMIN_V = GAP_MIN[9:0];

    state_t            cur_st, nxt_st;
    logic [2:0][10:0]  x_q, x_d;
    logic [2:0][9:0]   gy_q, gy_d;
    logic [2:0]        act_q, act_d;
    logic [7:0]        score_q, score_d;
    logic              pass_q, pass_d;
    logic              miss_q, miss_d;
    logic [9:0]        dist_q, dist_d;
    logic [15:0]       lfsr_q;
    logic [9:0]        new_gap;
    logic [1:0]        n_pass;
    logic [8:0]        score_sum;
    logic [10:0]       dist_sum;
    logic              spawned;

    // Gap for any spawn this cycle comes from the current LFSR value.
    assign new_gap = GAPMIN_V + {2'b00, lfsr_q[7:0]};

    // Free-running Fibonacci LFSR (taps 16,14,13,11), reseeded only by reset.
    always_ff @(posedge clk) begin
        if (initalize) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // State and field registers; reset overrides every other input.
    always_ff @(posedge clk) begin
        if (initalize) begin
            cur_st  <= IDLE;
            x_q     <= '0;
            gy_q    <= '0;
            act_q   <= '0;
            score_q <= '0;
            pass_q  <= 1'b0;
            miss_q  <= 1'b0;
            dist_q  <= '0;
        end else begin
            cur_st  <= nxt_st;
            x_q     <= x_d;
            gy_q    <= gy_d;
            act_q   <= act_d;
            score_q <= score_d;
            pass_q  <= pass_d;
            miss_q  <= miss_d;
            dist_q  <= dist_d;
        end
    end

    // Next state: restart on start, scroll/score/spawn on frame_tick in RUN, freeze in HALT.
    always_comb begin
        nxt_st    = cur_st;
        x_d       = x_q;
        gy_d      = gy_q;
        act_d     = act_q;
        score_d   = score_q;
        pass_d    = 1'b0;
        miss_d    = miss_q;
        dist_d    = dist_q;
        n_pass    = 2'd0;
        score_sum = 9'd0;
        dist_sum  = 11'd0;
        spawned   = 1'b0;

        case (cur_st)
            RUN: begin
                if (halt) begin
                    nxt_st = HALT;
                end else if (frame_tick) begin
                    // Scroll or retire each live slot; a retiring slot keeps its x.
                    for (int i = 0; i < 3; i++) begin
                        if (act_q[i]) begin
                            if (x_q[i] < SPEED_V) begin
                                act_d[i] = 1'b0;
                            end else begin
                                x_d[i] = x_q[i] - SPEED_V;
                                if (x_q[i] >= BIRD_V && x_d[i] < BIRD_V) begin
                                    n_pass = n_pass + 2'd1;
                                end
                            end
                        end
                    end
                    score_sum = {1'b0, score_q} + {7'd0, n_pass};
                    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
                    pass_d    = (n_pass != 2'd0);
                    // Spawn into the lowest slot free after scrolling; a retiree counts as free.
                    dist_sum = {1'b0, dist_q} + SPEED_V;
                    if (dist_sum >= SPACE_V) begin
                        dist_d = '0;
                        for (int i = 0; i < 3; i++) begin
                            if (!spawned && !act_d[i]) begin
                                spawned  = 1'b1;
                                act_d[i] = 1'b1;
                                x_d[i]   = SPAWN_XV;
                                gy_d[i]  = new_gap;
                            end
                        end
                        if (!spawned) begin
                            miss_d = 1'b1;
                        end
                    end else begin
                        dist_d = dist_sum[9:0];
                    end
                end
            end
            default: begin
                // IDLE and HALT: only start matters; it clears the field and spawns slot 0.
                if (start) begin
                    nxt_st   = RUN;
                    x_d      = '0;
                    gy_d     = '0;
                    act_d    = 3'b001;
                    x_d[0]   = SPAWN_XV;
                    gy_d[0]  = new_gap;
                    score_d  = '0;
                    miss_d   = 1'b0;
                    dist_d   = '0;
                end
            end
        endcase
    end

    assign pipe_x0     = x_q[0];
    assign pipe_x1     = x_q[1];
    assign pipe_x2     = x_q[2];
    assign gap_y0      = gy_q[0];
    assign gap_y1      = gy_q[1];
    assign gap_y2      = gy_q[2];
    assign pipe_active = act_q;
    assign score       = score_q;
    assign pass_pulse  = pass_q;
    assign spawn_miss  = miss_q;
    assign state       = cur_st;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Purpose: checks pipe_scheduler against a frame-level model plus hand-computed checkpoints.
// Latency: expects every input effect one cycle after it is sampled.
// Backpressure: none; stimulus is a sequence of single-cycle pulses.
module tb_pipe_scheduler;

    logic        clk = 1'b0;
    logic        initalize = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic        frame_tick = 1'b0;

    logic [10:0] pipe_x0, pipe_x1, pipe_x2;
    logic [9:0]  gap_y0, gap_y1, gap_y2;
    logic [2:0]  pipe_active;
    logic [7:0]  score;
    logic        pass_pulse, spawn_miss;
    logic [1:0]  state;

    logic [10:0] b_x0, b_x1, b_x2;
    logic [9:0]  b_g0, b_g1, b_g2;
    logic [2:0]  b_active;
    logic [7:0]  b_score;
    logic        b_pass, b_miss;
    logic [1:0]  b_state;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_scheduler dut (
        .clk(clk), .initalize(initalize), .start(start), .halt(halt), .frame_tick(frame_tick),
        .pipe_x0(pipe_x0), .pipe_x1(pipe_x1), .pipe_x2(pipe_x2),
        .gap_y0(gap_y0), .gap_y1(gap_y1), .gap_y2(gap_y2),
        .pipe_active(pipe_active), .score(score), .pass_pulse(pass_pulse),
        .spawn_miss(spawn_miss), .state(state)
    );

    pipe_scheduler #(.SPACING(40)) dut_b (
        .clk(clk), .initalize(initalize), .start(start), .halt(halt), .frame_tick(frame_tick),
        .pipe_x0(b_x0), .pipe_x1(b_x1), .pipe_x2(b_x2),
        .gap_y0(b_g0), .gap_y1(b_g1), .gap_y2(b_g2),
        .pipe_active(b_active), .score(b_score), .pass_pulse(b_pass),
        .spawn_miss(b_miss), .state(b_state)
    );

    function automatic void chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- frame-level model of the default-parameter DUT ----------------
    int   m_x[3], m_g[3];
    bit   m_act[3];
    int   m_score, m_dist, m_state;
    bit   m_pass, m_miss, m_valid = 1'b0;
    logic [15:0] m_lfsr;

    always @(posedge clk) begin
        int gap, passed, slot;
        if (initalize) begin
            for (int i = 0; i < 3; i++) begin m_x[i] = 0; m_g[i] = 0; m_act[i] = 0; end
            m_score = 0; m_dist = 0; m_state = 0; m_pass = 0; m_miss = 0;
            m_lfsr = 16'hACE1;
            m_valid = 1'b1;
        end else begin
            gap = (100 + int'(m_lfsr[7:0])) % 1024;
            m_pass = 0;
            if (m_state == 1) begin
                if (halt) m_state = 2;
                else if (frame_tick) begin
                    passed = 0;
                    for (int i = 0; i < 3; i++) begin
                        if (m_act[i]) begin
                            if (m_x[i] < 4) m_act[i] = 0;
                            else begin
                                if (m_x[i] >= 160 && m_x[i] - 4 < 160) passed++;
                                m_x[i] = m_x[i] - 4;
                            end
                        end
                    end
                    m_score = (m_score + passed > 255) ? 255 : m_score + passed;
                    m_pass = (passed > 0);
                    if (m_dist + 4 >= 240) begin
                        m_dist = 0;
                        slot = -1;
                        for (int i = 2; i >= 0; i--) if (!m_act[i]) slot = i;
                        if (slot < 0) m_miss = 1;
                        else begin m_act[slot] = 1; m_x[slot] = 640; m_g[slot] = gap; end
                    end else m_dist = m_dist + 4;
                end
            end else if (start) begin
                m_state = 1;
                for (int i = 0; i < 3; i++) begin m_x[i] = 0; m_g[i] = 0; m_act[i] = 0; end
                m_act[0] = 1; m_x[0] = 640; m_g[0] = gap;
                m_score = 0; m_dist = 0; m_miss = 0;
            end
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    // Compare every output against the model on every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("m.x0", pipe_x0, m_x[0]);
            chk("m.x1", pipe_x1, m_x[1]);
            chk("m.x2", pipe_x2, m_x[2]);
            chk("m.g0", gap_y0, m_g[0]);
            chk("m.g1", gap_y1, m_g[1]);
            chk("m.g2", gap_y2, m_g[2]);
            chk("m.active", pipe_active, {m_act[2], m_act[1], m_act[0]});
            chk("m.score", score, m_score);
            chk("m.pass", pass_pulse, m_pass);
            chk("m.miss", spawn_miss, m_miss);
            chk("m.state", state, m_state);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic r, input logic s, input logic h, input logic t);
        initalize = r; start = s; halt = h; frame_tick = t;
        @(posedge clk);
        #1;
        initalize = 1'b0; start = 1'b0; halt = 1'b0; frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 1);
    endtask

    initial begin
        bit seen;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst.state", state, 0);
        chk("rst.active", pipe_active, 0);
        chk("rst.score", score, 0);
        chk("rst.x0", pipe_x0, 0);

        // Start right after reset: LFSR still holds the seed, so gap = 100 + 0xE1.
        step(0, 1, 0, 0);
        chk("start.state", state, 1);
        chk("start.active", pipe_active, 3'b001);
        chk("start.x0", pipe_x0, 640);
        chk("start.gap0", gap_y0, 325);

        ticks(1);
        chk("t1.x0", pipe_x0, 636);
        ticks(28);
        chk("t29.b_miss", b_miss, 0);
        ticks(1);
        chk("t30.b_miss", b_miss, 1);
        chk("t30.b_active", b_active, 3'b111);
        ticks(30);
        chk("t60.x0", pipe_x0, 400);
        chk("t60.x1", pipe_x1, 640);
        chk("t60.active", pipe_active, 3'b011);
        ticks(60);
        chk("t120.active", pipe_active, 3'b111);
        chk("t120.x0", pipe_x0, 160);
        ticks(1);
        chk("t121.x0", pipe_x0, 156);
        chk("t121.score", score, 1);
        chk("t121.pass", pass_pulse, 1);
        step(0, 0, 0, 0);
        chk("idle.pass", pass_pulse, 0);
        ticks(40);
        chk("t161.active0", pipe_active[0], 0);
        chk("t161.x0", pipe_x0, 0);
        ticks(19);
        chk("t180.active", pipe_active, 3'b111);
        chk("t180.x0", pipe_x0, 640);

        // Halt beats a simultaneous tick; HALT ignores ticks and halts.
        step(0, 0, 1, 1);
        chk("halt.state", state, 2);
        chk("halt.x0", pipe_x0, 640);
        chk("halt.x1", pipe_x1, 160);
        ticks(3);
        step(0, 0, 1, 0);
        chk("halt2.state", state, 2);
        chk("halt2.x1", pipe_x1, 160);
        chk("halt2.score", score, 1);
        step(0, 1, 0, 0);
        chk("restart.state", state, 1);
        chk("restart.active", pipe_active, 3'b001);
        chk("restart.score", score, 0);
        chk("restart.x0", pipe_x0, 640);
        chk("restart.b_miss", b_miss, 0);

        // Long run to saturate the score, then one more pass.
        ticks(15500);
        chk("sat.score", score, 255);
        seen = 1'b0;
        for (int i = 0; i < 120 && !seen; i++) begin
            ticks(1);
            if (pass_pulse) seen = 1'b1;
        end
        chk("sat.pass_seen", seen, 1);
        chk("sat.score2", score, 255);

        // Reset mid-run with other inputs active.
        step(1, 1, 0, 1);
        chk("rrun.state", state, 0);
        chk("rrun.active", pipe_active, 0);
        chk("rrun.score", score, 0);
        chk("rrun.x0", pipe_x0, 0);
        chk("rrun.gap0", gap_y0, 0);
        chk("rrun.pass", pass_pulse, 0);
        chk("rrun.miss", spawn_miss, 0);
        chk("rrun.b_miss", b_miss, 0);
        chk("rrun.b_active", b_active, 0);
        step(0, 0, 1, 0);
        chk("idle_halt.state", state, 0);
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
